// File: rtl/ibex_trace_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ibex_trace_fifo                                                          |
// | Buffers RVFI retirement records for a slow trace sink; counts drops.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ibex_trace_fifo #(
    parameter int unsigned Depth        = 8,
    parameter int unsigned DropCntWidth = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      trace_en_i,
    input  logic                      trace_flush_i,
    input  logic                      rvfi_valid,
    input  logic                      rvfi_trap,
    input  logic                      rvfi_intr,
    input  logic                      rvfi_halt,
    input  logic [1:0]                rvfi_mode,
    input  logic [31:0]               rvfi_insn,
    input  logic [31:0]               rvfi_pc_rdata,
    input  logic [31:0]               rvfi_rd_wdata,
    input  logic [31:0]               rvfi_mem_addr,
    input  logic [4:0]                rvfi_rd_addr,
    input  logic [3:0]                rvfi_mem_rmask,
    input  logic [3:0]                rvfi_mem_wmask,
    output logic                      trace_valid_o,
    input  logic                      trace_ready_i,
    output logic [31:0]               trace_pc_o,
    output logic [31:0]               trace_insn_o,
    output logic [31:0]               trace_rd_wdata_o,
    output logic [31:0]               trace_mem_addr_o,
    output logic [4:0]                trace_rd_addr_o,
    output logic [3:0]                trace_mem_rmask_o,
    output logic [3:0]                trace_mem_wmask_o,
    output logic [1:0]                trace_mode_o,
    output logic                      trace_trap_o,
    output logic                      trace_intr_o,
    output logic                      trace_halt_o,
    output logic [DropCntWidth-1:0]   trace_drop_cnt_o,
    output logic [$clog2(Depth):0]    trace_level_o,
    output logic                      overflow_o
);

    localparam int unsigned PTR_W = $clog2(Depth);

    localparam logic [PTR_W-1:0]        c_PTR_ONE  = 1;
    localparam logic [PTR_W:0]          c_CNT_ONE  = 1;
    localparam logic [PTR_W:0]          c_FULL_LVL = Depth[PTR_W:0];
    localparam logic [DropCntWidth-1:0] c_DROP_MAX = '1;
    localparam logic [DropCntWidth-1:0] c_DROP_ONE = 1;

    typedef struct packed {
        logic [DropCntWidth-1:0] drop;
        logic [31:0]             pc;
        logic [31:0]             insn;
        logic [31:0]             rd_wdata;
        logic [31:0]             mem_addr;
        logic [4:0]              rd_addr;
        logic [3:0]              rmask;
        logic [3:0]              wmask;
        logic [1:0]              mode;
        logic                    trap;
        logic                    intr;
        logic                    halt;
    } rec_t;

    rec_t                    r_mem [Depth];
    logic [PTR_W-1:0]        r_wptr;
    logic [PTR_W-1:0]        r_rptr;
    logic [PTR_W:0]          r_count;
    logic [DropCntWidth-1:0] r_drop_cnt;
    logic                    r_overflow;

    logic                    w_push_req;
    logic                    w_full;
    logic                    w_pop;
    logic                    w_push_ok;
    logic                    w_drop;
    rec_t                    w_rec;
    rec_t                    w_head;

    assign w_push_req = rvfi_valid & trace_en_i & ~trace_flush_i;
    assign w_full     = (r_count == c_FULL_LVL);
    assign w_pop      = trace_valid_o & trace_ready_i;
    // A full FIFO can still take a record when the head leaves this cycle.
    assign w_push_ok  = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;

    always_comb begin
        w_rec          = '0;
        w_rec.drop     = r_drop_cnt;
        w_rec.pc       = rvfi_pc_rdata;
        w_rec.insn     = rvfi_insn;
        w_rec.rd_wdata = rvfi_rd_wdata;
        w_rec.mem_addr = rvfi_mem_addr;
        w_rec.rd_addr  = rvfi_rd_addr;
        w_rec.rmask    = rvfi_mem_rmask;
        w_rec.wmask    = rvfi_mem_wmask;
        w_rec.mode     = rvfi_mode;
        w_rec.trap     = rvfi_trap;
        w_rec.intr     = rvfi_intr;
        w_rec.halt     = rvfi_halt;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push_ok) begin
            r_mem[r_wptr] <= w_rec;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (trace_flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (!w_push_ok && w_pop) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    // Drops pending at flush time are intentionally discarded.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else if (trace_flush_i) begin
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else if (w_push_ok) begin
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != c_DROP_MAX) begin
                r_drop_cnt <= r_drop_cnt + c_DROP_ONE;
            end
        end
    end

    assign w_head            = r_mem[r_rptr];
    assign trace_valid_o     = (r_count != '0);
    assign trace_pc_o        = w_head.pc;
    assign trace_insn_o      = w_head.insn;
    assign trace_rd_wdata_o  = w_head.rd_wdata;
    assign trace_mem_addr_o  = w_head.mem_addr;
    assign trace_rd_addr_o   = w_head.rd_addr;
    assign trace_mem_rmask_o = w_head.rmask;
    assign trace_mem_wmask_o = w_head.wmask;
    assign trace_mode_o      = w_head.mode;
    assign trace_trap_o      = w_head.trap;
    assign trace_intr_o      = w_head.intr;
    assign trace_halt_o      = w_head.halt;
    assign trace_drop_cnt_o  = w_head.drop;
    assign trace_level_o     = r_count;
    assign overflow_o        = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ibex_trace_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ibex_trace_fifo                                                       |
// | Self-checking bench: queue model of the trace FIFO plus literal checks.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_ibex_trace_fifo;

    localparam int DEPTH = 8;
    localparam int DCW   = 4;
    localparam int DMAX  = (1 << DCW) - 1;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic trace_en_i = 1'b0, trace_flush_i = 1'b0, trace_ready_i = 1'b0;
    logic rvfi_valid = 1'b0, rvfi_trap = 1'b0, rvfi_intr = 1'b0, rvfi_halt = 1'b0;
    logic [1:0]  rvfi_mode = '0;
    logic [31:0] rvfi_insn = '0, rvfi_pc_rdata = '0, rvfi_rd_wdata = '0, rvfi_mem_addr = '0;
    logic [4:0]  rvfi_rd_addr = '0;
    logic [3:0]  rvfi_mem_rmask = '0, rvfi_mem_wmask = '0;

    logic            trace_valid_o, trace_trap_o, trace_intr_o, trace_halt_o, overflow_o;
    logic [31:0]     trace_pc_o, trace_insn_o, trace_rd_wdata_o, trace_mem_addr_o;
    logic [4:0]      trace_rd_addr_o;
    logic [3:0]      trace_mem_rmask_o, trace_mem_wmask_o;
    logic [1:0]      trace_mode_o;
    logic [DCW-1:0]  trace_drop_cnt_o;
    logic [3:0]      trace_level_o;

    int errors = 0;
    int checks = 0;

    ibex_trace_fifo #(.Depth(DEPTH), .DropCntWidth(DCW)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .trace_en_i(trace_en_i), .trace_flush_i(trace_flush_i),
        .rvfi_valid(rvfi_valid), .rvfi_trap(rvfi_trap), .rvfi_intr(rvfi_intr),
        .rvfi_halt(rvfi_halt), .rvfi_mode(rvfi_mode), .rvfi_insn(rvfi_insn),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_rd_addr(rvfi_rd_addr),
        .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
        .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
        .trace_pc_o(trace_pc_o), .trace_insn_o(trace_insn_o),
        .trace_rd_wdata_o(trace_rd_wdata_o), .trace_mem_addr_o(trace_mem_addr_o),
        .trace_rd_addr_o(trace_rd_addr_o), .trace_mem_rmask_o(trace_mem_rmask_o),
        .trace_mem_wmask_o(trace_mem_wmask_o), .trace_mode_o(trace_mode_o),
        .trace_trap_o(trace_trap_o), .trace_intr_o(trace_intr_o),
        .trace_halt_o(trace_halt_o), .trace_drop_cnt_o(trace_drop_cnt_o),
        .trace_level_o(trace_level_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every record field is derived from its PC so the model only stores PC + drop count.
    function automatic logic [31:0] f_insn(input logic [31:0] pc);  return pc ^ 32'hdead0000; endfunction
    function automatic logic [31:0] f_wdata(input logic [31:0] pc); return pc + 32'd1;        endfunction
    function automatic logic [31:0] f_maddr(input logic [31:0] pc); return ~pc;               endfunction

    typedef struct {
        logic [31:0] pc;
        int          drop;
    } mrec_t;

    mrec_t mq[$];
    int    m_drop = 0;
    bit    m_ovf  = 1'b0;

    // Compare DUT against the model, then advance the model with the inputs
    // that the next rising edge will sample.
    always @(negedge clk) begin
        if (!rst_ni) begin
            mq.delete();
            m_drop = 0;
            m_ovf  = 1'b0;
        end else begin
            chk("valid", 64'(trace_valid_o), 64'(mq.size() != 0));
            chk("level", 64'(trace_level_o), 64'(mq.size()));
            chk("overflow", 64'(overflow_o), 64'(m_ovf));
            if (mq.size() != 0) begin
                chk("pc", 64'(trace_pc_o), 64'(mq[0].pc));
                chk("insn", 64'(trace_insn_o), 64'(f_insn(mq[0].pc)));
                chk("rd_wdata", 64'(trace_rd_wdata_o), 64'(f_wdata(mq[0].pc)));
                chk("mem_addr", 64'(trace_mem_addr_o), 64'(f_maddr(mq[0].pc)));
                chk("rd_addr", 64'(trace_rd_addr_o), 64'(mq[0].pc[6:2]));
                chk("masks", 64'({trace_mem_rmask_o, trace_mem_wmask_o}), 64'(mq[0].pc[7:0]));
                chk("mode", 64'(trace_mode_o), 64'(mq[0].pc[9:8]));
                chk("flags", 64'({trace_trap_o, trace_intr_o, trace_halt_o}),
                    64'({mq[0].pc[2], mq[0].pc[3], mq[0].pc[4]}));
                chk("drop_cnt", 64'(trace_drop_cnt_o), 64'(mq[0].drop));
            end
            if (trace_flush_i) begin
                mq.delete();
                m_drop = 0;
                m_ovf  = 1'b0;
            end else begin
                if (mq.size() != 0 && trace_ready_i) void'(mq.pop_front());
                if (rvfi_valid && trace_en_i) begin
                    if (mq.size() < DEPTH) begin
                        mq.push_back('{pc: rvfi_pc_rdata, drop: m_drop});
                        m_drop = 0;
                    end else begin
                        m_ovf = 1'b1;
                        if (m_drop < DMAX) m_drop++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ret(input logic [31:0] pc);
        rvfi_valid     = 1'b1;
        rvfi_pc_rdata  = pc;
        rvfi_insn      = f_insn(pc);
        rvfi_rd_wdata  = f_wdata(pc);
        rvfi_mem_addr  = f_maddr(pc);
        rvfi_rd_addr   = pc[6:2];
        rvfi_mem_rmask = pc[7:4];
        rvfi_mem_wmask = pc[3:0];
        rvfi_mode      = pc[9:8];
        rvfi_trap      = pc[2];
        rvfi_intr      = pc[3];
        rvfi_halt      = pc[4];
    endtask

    task automatic retire_n(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            set_ret(base + 32'(4 * i));
            tick();
        end
        rvfi_valid = 1'b0;
    endtask

    // Waits (bounded) for the head to show the given PC; returns at that cycle.
    task automatic wait_head(input logic [31:0] pc, input int budget);
        int n = 0;
        while (!(trace_valid_o && trace_pc_o == pc) && n < budget) begin
            tick();
            n++;
        end
        chk("wait_head_timeout", 64'(n < budget), 64'd1);
    endtask

    task automatic drain();
        trace_ready_i = 1'b1;
        for (int i = 0; i < 20 && trace_level_o != 0; i++) tick();
        chk("drained", 64'(trace_level_o), 64'd0);
    endtask

    initial begin
        // Reset: everything reads zero.
        tick(); tick();
        chk("rst_valid", 64'(trace_valid_o), 64'd0);
        chk("rst_level", 64'(trace_level_o), 64'd0);
        chk("rst_ovf", 64'(overflow_o), 64'd0);
        chk("rst_pc", 64'(trace_pc_o), 64'd0);
        chk("rst_drop", 64'(trace_drop_cnt_o), 64'd0);
        rst_ni = 1'b1;
        tick();

        // Three back-to-back retirements with the sink always ready.
        trace_en_i    = 1'b1;
        trace_ready_i = 1'b1;
        set_ret(32'h100); tick();
        chk("pc100", 64'(trace_pc_o), 64'h100);
        chk("lvl1_a", 64'(trace_level_o), 64'd1);
        set_ret(32'h104); tick();
        chk("pc104", 64'(trace_pc_o), 64'h104);
        set_ret(32'h108); tick();
        chk("pc108", 64'(trace_pc_o), 64'h108);
        chk("lvl1_b", 64'(trace_level_o), 64'd1);
        rvfi_valid = 1'b0;
        tick();
        chk("empty_after3", 64'(trace_valid_o), 64'd0);

        // Overfill: 11 retirements into 8 slots, then a slot-reuse push.
        trace_ready_i = 1'b0;
        retire_n(32'h300, 11);
        chk("full_lvl", 64'(trace_level_o), 64'd8);
        chk("full_ovf", 64'(overflow_o), 64'd1);
        trace_ready_i = 1'b1;
        set_ret(32'h200); tick();
        rvfi_valid = 1'b0;
        chk("reuse_lvl", 64'(trace_level_o), 64'd8);
        wait_head(32'h200, 20);
        chk("drop3", 64'(trace_drop_cnt_o), 64'd3);
        drain();

        // Full FIFO with simultaneous push and pop keeps level at 8.
        trace_ready_i = 1'b0;
        retire_n(32'h400, 8);
        trace_ready_i = 1'b1;
        set_ret(32'h500); tick();
        rvfi_valid    = 1'b0;
        trace_ready_i = 1'b0;
        chk("pushpop_lvl", 64'(trace_level_o), 64'd8);

        // One drop to leave a pending count, then flush alongside a retirement.
        set_ret(32'h600); tick();
        chk("ovf_before_flush", 64'(overflow_o), 64'd1);
        trace_flush_i = 1'b1;
        set_ret(32'h604); tick();
        trace_flush_i = 1'b0;
        rvfi_valid    = 1'b0;
        chk("flush_lvl", 64'(trace_level_o), 64'd0);
        chk("flush_valid", 64'(trace_valid_o), 64'd0);
        chk("flush_ovf", 64'(overflow_o), 64'd0);
        set_ret(32'h608); tick();
        rvfi_valid = 1'b0;
        chk("post_flush_drop", 64'(trace_drop_cnt_o), 64'd0);
        drain();

        // Capture disabled: retirements are neither stored nor dropped.
        trace_en_i = 1'b0;
        retire_n(32'h700, 5);
        tick();
        chk("dis_lvl", 64'(trace_level_o), 64'd0);
        chk("dis_ovf", 64'(overflow_o), 64'd0);
        trace_en_i = 1'b1;

        // Saturation: fill, 20 drops, free one slot, push one record.
        trace_ready_i = 1'b0;
        retire_n(32'h800, 8);
        retire_n(32'h900, 20);
        trace_ready_i = 1'b1; tick();
        trace_ready_i = 1'b0;
        set_ret(32'ha00); tick();
        rvfi_valid    = 1'b0;
        trace_ready_i = 1'b1;
        wait_head(32'ha00, 20);
        chk("drop_sat", 64'(trace_drop_cnt_o), 64'd15);
        drain();

        // Asynchronous reset mid-stream discards contents.
        trace_ready_i = 1'b0;
        retire_n(32'hb00, 3);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_rst_lvl", 64'(trace_level_o), 64'd0);
        chk("async_rst_valid", 64'(trace_valid_o), 64'd0);
        tick();
        rst_ni = 1'b1;
        tick(); tick();
        chk("post_rst_valid", 64'(trace_valid_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
